// File: rtl/square_rain_engine_pkg.sv
// Shared FSM encoding, screen/colour defaults and LFSR helper for the square rain engine.
// The LFSR items exist only when SQ_RESPAWN_RAND_EN is defined.
package square_rain_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_MOVE,
    ST_DRAW,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;
  localparam int unsigned COLOR_W_DEF  = 3;
  localparam logic [COLOR_W_DEF-1:0] FG_COLOR_DEF = 3'b100;
  localparam logic [COLOR_W_DEF-1:0] BG_COLOR_DEF = 3'b000;

`ifdef SQ_RESPAWN_RAND_EN
  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  // Fibonacci step, taps 8,6,5,4.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
`endif

endpackage

// File: rtl/square_rain_engine_pixel_scan.sv
// Row-major dx/dy scan over one SQ_SIZE x SQ_SIZE square; done_c flags the final pixel.
module square_pixel_scan #(
  parameter int unsigned SQ_SIZE = 4,
  parameter int unsigned C_W     = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           run,
  output logic [C_W-1:0] dx,
  output logic [C_W-1:0] dy,
  output logic           done_c
);

  logic row_end_c;
  logic col_end_c;

  assign row_end_c = (dx == C_W'(SQ_SIZE - 1));
  assign col_end_c = (dy == C_W'(SQ_SIZE - 1));
  assign done_c    = run && row_end_c && col_end_c;

  // Counter wraps to (0,0) after the last pixel, so each scan starts clean.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dx <= '0;
      dy <= '0;
    end else if (run) begin
      if (row_end_c) begin
        dx <= '0;
        dy <= col_end_c ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_rain_engine.sv
// Falling-squares drawing engine: erase, move and redraw every square once per frame tick.
// Define SQ_RESPAWN_RAND_EN to respawn wrapped squares at an LFSR-chosen column.
module square_rain_engine
  import square_rain_engine_pkg::*;
#(
  parameter int unsigned NUM_SQ   = 4,
  parameter int unsigned SQ_SIZE  = 4,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOR_W  = COLOR_W_DEF,
  parameter logic [COLOR_W-1:0] FG_COLOR = FG_COLOR_DEF,
  parameter logic [COLOR_W-1:0] BG_COLOR = BG_COLOR_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               busy,
  output logic               finish_drawing,
  output logic               overrun
);

  localparam int unsigned IDX_W   = (NUM_SQ > 1) ? $clog2(NUM_SQ) : 1;
  localparam int unsigned C_W     = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
  localparam int unsigned X_PITCH = SCREEN_W / NUM_SQ;
  localparam int unsigned Y_PITCH = (SCREEN_H - SQ_SIZE) / NUM_SQ;
  localparam int unsigned Y_MAX   = SCREEN_H - SQ_SIZE;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [X_W-1:0]     sq_x [NUM_SQ];
  logic [Y_W-1:0]     sq_y [NUM_SQ];
  logic [C_W-1:0]     dx;
  logic [C_W-1:0]     dy;
  logic               scan_run;
  logic               scan_done_c;
  logic [Y_W:0]       y_sum;
  logic               wrap;
  logic [X_W-1:0]     x_next;
  logic [Y_W-1:0]     y_next;
  logic [COLOR_W-1:0] color_next;
  logic               plot_next;

  square_pixel_scan #(
    .SQ_SIZE (SQ_SIZE),
    .C_W     (C_W)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .run    (scan_run),
    .dx     (dx),
    .dy     (dy),
    .done_c (scan_done_c)
  );

  // One extra bit so the bottom-edge test cannot overflow.
  assign y_sum = {1'b0, sq_y[idx]} + (Y_W+1)'(STEP);
  assign wrap  = (y_sum > (Y_W+1)'(Y_MAX));

`ifdef SQ_RESPAWN_RAND_EN
  localparam int unsigned X_RANGE = SCREEN_W - SQ_SIZE;

  logic [LFSR_W-1:0] lfsr;
  logic [X_W-1:0]    x_respawn;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_advance(lfsr);
  end

  assign x_respawn = ({1'b0, lfsr} >= (LFSR_W+1)'(X_RANGE))
                   ? X_W'(lfsr - LFSR_W'(X_RANGE)) : X_W'(lfsr);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and the pixel presented on the following cycle.
  always_comb begin
    state_next = state;
    scan_run   = 1'b0;
    plot_next  = 1'b0;
    color_next = BG_COLOR;
    x_next     = sq_x[idx] + X_W'(dx);
    y_next     = sq_y[idx] + Y_W'(dy);
    case (state)
      ST_IDLE:  if (frame_tick && enable) state_next = ST_ERASE;
      ST_ERASE: begin
        scan_run  = 1'b1;
        plot_next = 1'b1;
        if (scan_done_c) state_next = ST_MOVE;
      end
      ST_MOVE:  state_next = ST_DRAW;
      ST_DRAW:  begin
        scan_run   = 1'b1;
        plot_next  = 1'b1;
        color_next = FG_COLOR;
        if (scan_done_c) state_next = ST_NEXT;
      end
      ST_NEXT:  state_next = (idx == IDX_W'(NUM_SQ - 1)) ? ST_DONE : ST_ERASE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      for (int i = 0; i < NUM_SQ; i++) begin
        sq_x[i] <= X_W'(i * X_PITCH);
        sq_y[i] <= Y_W'(i * Y_PITCH);
      end
    end else begin
      if (state == ST_IDLE) begin
        idx <= '0;
      end else if (state == ST_NEXT && state_next == ST_ERASE) begin
        idx <= idx + 1'b1;
      end
      if (state == ST_MOVE) begin
        sq_y[idx] <= wrap ? '0 : y_sum[Y_W-1:0];
`ifdef SQ_RESPAWN_RAND_EN
        if (wrap) sq_x[idx] <= x_respawn;
`endif
      end
    end
  end

  // busy/finish follow the next state so a tick during DONE counts as overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x              <= '0;
      y              <= '0;
      color          <= '0;
      plot           <= 1'b0;
      busy           <= 1'b0;
      finish_drawing <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      x              <= x_next;
      y              <= y_next;
      color          <= color_next;
      plot           <= plot_next;
      busy           <= (state_next != ST_IDLE);
      finish_drawing <= (state_next == ST_DONE);
      if (frame_tick && state != ST_IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_square_rain_engine.sv
// Directed self-checking bench for square_rain_engine (default parameters).
// With SQ_RESPAWN_RAND_EN defined a second 1x8x8 instance checks LFSR respawn columns.
module tb_square_rain_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       frame_tick;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot;
  logic       busy;
  logic       finish_drawing;
  logic       overrun;

  int          checks = 0;
  int          passed = 0;
  logic [17:0] px [128];
  int          n_plot;
  int          fin_cnt;
  int          fin_cyc;
  logic        busy_c1;

  always #5 clock = ~clock;

  square_rain_engine dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .frame_tick     (frame_tick),
    .x              (x),
    .y              (y),
    .color          (color),
    .plot           (plot),
    .busy           (busy),
    .finish_drawing (finish_drawing),
    .overrun        (overrun)
  );

`ifdef SQ_RESPAWN_RAND_EN
  logic       tick6;
  logic [7:0] x6;
  logic [6:0] y6;
  logic [2:0] color6;
  logic       plot6;
  logic       busy6;
  logic       fin6;
  logic       ovr6;
  logic [7:0] lfsr_m;
  logic [7:0] lfsr_cap;
  logic [7:0] x_exp;

  square_rain_engine #(.NUM_SQ(1), .SQ_SIZE(8)) dut6 (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .frame_tick     (tick6),
    .x              (x6),
    .y              (y6),
    .color          (color6),
    .plot           (plot6),
    .busy           (busy6),
    .finish_drawing (fin6),
    .overrun        (ovr6)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One tick, then 150 observed cycles; cycle 1 is the one right after the tick edge.
  task automatic run_frame(input bit tick_at50, input bit drop_en_at50);
    n_plot  = 0;
    fin_cnt = 0;
    fin_cyc = 0;
    @(negedge clock);
    frame_tick = 1'b1;
    @(posedge clock);
    #1 frame_tick = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clock);
      if (c == 1) busy_c1 = busy;
      if (plot) begin
        if (n_plot < 128) px[n_plot] = {x, y, color};
        n_plot++;
      end
      if (finish_drawing) begin
        fin_cnt++;
        fin_cyc = c;
      end
      frame_tick = tick_at50 && (c == 50);
      if (drop_en_at50 && c == 50) enable = 1'b0;
    end
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    frame_tick = 1'b0;
`ifdef SQ_RESPAWN_RAND_EN
    tick6      = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({x, y, color, plot, busy, finish_drawing, overrun}), 32'd0);

    // Abort a frame mid-draw of square 1.
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clock);
    frame_tick = 1'b1;
    @(posedge clock);
    #1 frame_tick = 1'b0;
    repeat (60) @(negedge clock);
    check("mid_plot_color", 32'({plot, color}), 32'({1'b1, 3'b100}));
    check("mid_xy", 32'({x, y}), 32'({8'd43, 7'd31}));
    reset = 1'b0;
    #1;
    check("async_reset", 32'({x, y, color, plot, busy, finish_drawing, overrun}), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Frame 1 from reset positions.
    run_frame(1'b0, 1'b0);
    check("f1_plot_count", 32'(n_plot), 32'd128);
    check("f1_finish_cycle", 32'(fin_cyc), 32'd137);
    check("f1_finish_count", 32'(fin_cnt), 32'd1);
    check("f1_busy_start", 32'(busy_c1), 32'd1);
    check("f1_busy_end", 32'(busy), 32'd0);
    check("f1_overrun", 32'(overrun), 32'd0);
    check("f1_px0", 32'(px[0]), 32'({8'd0, 7'd0, 3'd0}));
    check("f1_px5", 32'(px[5]), 32'({8'd1, 7'd1, 3'd0}));
    check("f1_px15", 32'(px[15]), 32'({8'd3, 7'd3, 3'd0}));
    check("f1_px16", 32'(px[16]), 32'({8'd0, 7'd1, 3'd4}));
    check("f1_px31", 32'(px[31]), 32'({8'd3, 7'd4, 3'd4}));
    check("f1_sq1_erase", 32'(px[32]), 32'({8'd40, 7'd29, 3'd0}));
    check("f1_sq1_draw", 32'(px[48]), 32'({8'd40, 7'd30, 3'd4}));
    check("f1_px127", 32'(px[127]), 32'({8'd123, 7'd91, 3'd4}));

    // Frame 2 with a tick arriving while busy.
    run_frame(1'b1, 1'b0);
    check("f2_finish_cycle", 32'(fin_cyc), 32'd137);
    check("f2_plot_count", 32'(n_plot), 32'd128);
    check("f2_overrun", 32'(overrun), 32'd1);
    check("f2_px0", 32'(px[0]), 32'({8'd0, 7'd1, 3'd0}));
    check("f2_px16", 32'(px[16]), 32'({8'd0, 7'd2, 3'd4}));

    // Tick with enable low starts nothing.
    enable = 1'b0;
    run_frame(1'b0, 1'b0);
    check("dis_plot_count", 32'(n_plot), 32'd0);
    check("dis_finish_count", 32'(fin_cnt), 32'd0);
    check("dis_overrun_sticky", 32'(overrun), 32'd1);

    // Frame 3: enable dropped mid-frame, frame still completes.
    enable = 1'b1;
    run_frame(1'b0, 1'b1);
    enable = 1'b1;
    check("f3_finish_cycle", 32'(fin_cyc), 32'd137);
    check("f3_plot_count", 32'(n_plot), 32'd128);

    for (int f = 4; f <= 29; f++) run_frame(1'b0, 1'b0);

    // Frame 30: square 3 erased at the bottom row, redrawn at the top.
    run_frame(1'b0, 1'b0);
    check("f30_sq0_erase", 32'(px[0]), 32'({8'd29 - 8'd29, 7'd29, 3'd0}));
    check("f30_sq3_erase", 32'(px[96]), 32'({8'd120, 7'd116, 3'd0}));
    check("f30_sq3_draw", 32'(px[112]), 32'({8'd120, 7'd0, 3'd4}));
    check("f30_px127", 32'(px[127]), 32'({8'd123, 7'd3, 3'd4}));

    run_frame(1'b0, 1'b0);
    check("f31_sq3_erase", 32'(px[96]), 32'({8'd120, 7'd0, 3'd0}));
    check("f31_sq3_draw", 32'(px[112]), 32'({8'd120, 7'd1, 3'd4}));
    check("f31_overrun_sticky", 32'(overrun), 32'd1);

    @(negedge clock);
    reset = 1'b0;
    #1;
    check("overrun_cleared", 32'(overrun), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

`ifdef SQ_RESPAWN_RAND_EN
    // 1x8x8: frame 113 is the first wrap; first draw pixel shows the respawn column.
    for (int f = 1; f <= 113; f++) begin
      @(negedge clock);
      tick6 = 1'b1;
      @(posedge clock);
      #1 tick6 = 1'b0;
      for (int c = 1; c <= 135; c++) begin
        @(negedge clock);
        if (c == 65) lfsr_cap = lfsr_m;
        if (c == 67 && f == 113) begin
          x_exp = (lfsr_cap >= 8'd152) ? lfsr_cap - 8'd152 : lfsr_cap;
          check("rand_wrap_y", 32'({plot6, color6, y6}), 32'({1'b1, 3'd4, 7'd0}));
          check("rand_x_model", 32'(x6), 32'(x_exp));
          check("rand_x_range", 32'(x6 <= 8'd152), 32'd1);
        end
      end
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
